// File: rtl/knn_topk_vote.sv
// kNN top-K selector and majority voter: keeps the K nearest train results,
// fetches their labels from image memory and presents the winning class.
module knn_topk_vote #(
  parameter int          K              = 5,
  parameter int          NUM_CLASS      = 10,
  parameter logic [31:0] IMAGE_OFFSET   = 32'h0001_0000,
  parameter int          DATA_LENGTH    = 3073,
  parameter int          NUM_TEST_IMAGE = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dist,
  input  logic [31:0] in_idx,
  input  logic        in_last,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        out_valid,
  output logic [31:0] out_label,
  input  logic        out_ready
);

  localparam int          CW        = $clog2(K + 1);
  localparam logic [31:0] REC_BYTES = 32'(DATA_LENGTH * 4);
  localparam logic [31:0] TEST_OFS  = 32'(NUM_TEST_IMAGE);

  typedef enum logic [1:0] {
    COLLECT,
    FETCH,
    VOTE,
    OUTPUT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   i_q, i_d;
  logic [31:0]     dist_q  [K];
  logic [31:0]     dist_d  [K];
  logic [31:0]     idx_q   [K];
  logic [31:0]     idx_d   [K];
  logic [31:0]     label_q [K];
  logic [31:0]     label_d [K];
  logic            mem_valid_q, mem_valid_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_label_q, out_label_d;

  int              pos;
  logic [31:0]     sel_idx;
  logic [CW-1:0]   cnt [NUM_CLASS];
  logic [CW-1:0]   best;
  logic [31:0]     win;

  assign in_ready  = (state_q == COLLECT);
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_label = out_label_q;

  // First slot holding a strictly larger distance; K means "not kept".
  always_comb begin
    pos = K;
    for (int j = K - 1; j >= 0; j--)
      if (in_dist < dist_q[j]) pos = j;
  end

  always_comb begin
    sel_idx = '0;
    for (int j = 0; j < K; j++)
      if (i_q == CW'(j)) sel_idx = idx_q[j];
  end

  // Strict > on ascending labels makes ties go to the smaller class.
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) cnt[c] = '0;
    for (int j = 0; j < K; j++)
      for (int c = 0; c < NUM_CLASS; c++)
        if (CW'(j) < count_q && label_q[j] == 32'(c))
          cnt[c] = cnt[c] + CW'(1);
    best = '0;
    win  = '0;
    for (int c = 0; c < NUM_CLASS; c++)
      if (cnt[c] > best) begin
        best = cnt[c];
        win  = 32'(c);
      end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    i_d         = i_q;
    dist_d      = dist_q;
    idx_d       = idx_q;
    label_d     = label_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_label_d = out_label_q;

    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (pos < K) begin
            for (int j = 0; j < K; j++) begin
              if (j > pos) begin
                dist_d[j] = dist_q[j-1];
                idx_d[j]  = idx_q[j-1];
              end else if (j == pos) begin
                dist_d[j] = in_dist;
                idx_d[j]  = in_idx;
              end
            end
            if (count_q != CW'(K)) count_d = count_q + CW'(1);
          end
          if (in_last) begin
            state_d = FETCH;
            i_d     = '0;
          end
        end
      end
      FETCH: begin
        if (mem_valid_q) begin
          if (mem_ready) begin
            for (int j = 0; j < K; j++)
              if (i_q == CW'(j)) label_d[j] = mem_rdata;
            mem_valid_d = 1'b0;
            i_d         = i_q + CW'(1);
          end
        end else if (i_q < count_q) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = IMAGE_OFFSET
                      + (sel_idx + TEST_OFS) * REC_BYTES;
        end else begin
          state_d = VOTE;
        end
      end
      VOTE: begin
        out_label_d = win;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          count_d     = '0;
          for (int j = 0; j < K; j++) begin
            dist_d[j] = '1;
            idx_d[j]  = '0;
          end
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (clear) begin
      state_d     = COLLECT;
      count_d     = '0;
      i_d         = '0;
      mem_valid_d = 1'b0;
      out_valid_d = 1'b0;
      for (int j = 0; j < K; j++) begin
        dist_d[j] = '1;
        idx_d[j]  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      i_q         <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_label_q <= '0;
      for (int j = 0; j < K; j++) begin
        dist_q[j]  <= '1;
        idx_q[j]   <= '0;
        label_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      i_q         <= i_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_label_q <= out_label_d;
      for (int j = 0; j < K; j++) begin
        dist_q[j]  <= dist_d[j];
        idx_q[j]   <= idx_d[j];
        label_q[j] <= label_d[j];
      end
    end
  end

endmodule

// File: doc/knn_topk_vote.md
Name: knn_topk_vote

Overview:
Downstream stage of the kNN L2-distance coprocessor. It consumes the stream of (distance, train-index) results, one per train image, and keeps a sorted list of the K smallest. After the last result it fetches the K labels from image memory, takes a majority vote, and presents the predicted class. One instance classifies one test image per pass and then re-arms itself.

Parameters:
K, 5, number of neighbours kept (1..8)
NUM_CLASS, 10, number of valid label values 0..NUM_CLASS-1
IMAGE_OFFSET, 32'h0001_0000, byte base address of the image/label array
DATA_LENGTH, 3073, words per image record (word 0 = label, words 1..3072 = pixels)
NUM_TEST_IMAGE, 50, record offset of train image 0

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort: empty the list and return to COLLECT
in_valid  in  1  distance result valid
in_ready  out  1  stage can accept a result
in_dist  in  32  unsigned L2 distance
in_idx  in  32  train image index (0-based)
in_last  in  1  marks the final result of the pass
mem_valid  out  1  label read request
mem_addr  out  32  byte address of the label word
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  read completes this cycle
out_valid  out  1  predicted label valid
out_label  out  32  predicted class
out_ready  in  1  consumer accepts out_label

Behaviour:
- Reset: state=COLLECT, list empty (count=0, all dist=32'hFFFF_FFFF, idx=0). in_ready=1. mem_valid=0, mem_addr=0. out_valid=0, out_label=0.
- States: COLLECT, FETCH, VOTE, OUTPUT.
- COLLECT: in_ready=1, so one result can be accepted per cycle. On an accepted result, compute insert position p = the first j with in_dist < dist[j] (strict, unsigned).
  - If p<K: shift entries p..K-2 down by one, write the new entry at p, count=min(count+1,K).
  - Equal distances keep arrival order, so the earlier-arriving index wins.
  - An update is visible to the next accepted result (no stall, no hazard).
  - If in_last is accepted: go to FETCH with i=0. This holds even for a single-result pass.
- FETCH: for i=0..count-1, in order:
  - Assert mem_valid with mem_addr = IMAGE_OFFSET + (idx[i]+NUM_TEST_IMAGE)*DATA_LENGTH*4 (32-bit wrap).
  - Hold mem_valid and mem_addr stable until mem_ready. Capture label[i]=mem_rdata in that cycle.
  - mem_valid is 0 in the cycle after each completion: at most one request is outstanding and there is one bubble between requests.
  - Entries i>=count are not fetched. After the last fetch, go to VOTE.
- VOTE (1 cycle): count each label in 0..NUM_CLASS-1; labels >= NUM_CLASS are ignored.
  - Winner = highest count; a tie goes to the smaller label value.
  - If no valid labels: winner=0.
  - Register out_label, set out_valid=1, go to OUTPUT.
- OUTPUT: out_valid and out_label are held stable until out_ready=1.
  - On acceptance: out_valid=0 in the next cycle, list emptied, return to COLLECT.
  - out_label keeps its last value after acceptance.
- in_ready=0 in FETCH, VOTE and OUTPUT. in_valid in those states is ignored, not queued.
- clear (priority over all other state updates):
  - Empties the list, drops mem_valid and out_valid, goes to COLLECT next cycle.
  - A result presented in the same cycle as clear is discarded.
  - An in-flight read abandoned by clear has its mem_ready/mem_rdata ignored.
- Asynchronous reset mid-pass gives the reset values immediately. There is no partial output.
- Label counters: ceil(log2(K+1)) bits. No overflow is possible.

Test Plan:
- Stream 8 results dist={90,10,50,10,70,5,200,30}, idx=0..7, last on idx7. Memory returns label=idx%3.
  -> list dist {5,10,10,30,50}, idx {5,1,3,7,2}.
  -> reads at 0x10000+(idx+50)*12292 in that order.
  -> labels {2,1,0,1,2}; counts 2:2, 1:2, 0:1; tie gives out_label=1.
- Single result dist=7, idx=3, last=1; memory returns 4.
  -> exactly one read at 0x10000+53*12292; out_label=4.
- mem_ready delayed 3 cycles on each read.
  -> mem_valid/mem_addr stable throughout; exactly 5 reads; correct vote.
- Hold out_ready=0 for 10 cycles in OUTPUT while driving in_valid=1.
  -> out_valid stays 1, out_label stable, in_ready=0, no result accepted; after out_ready, the next pass starts with an empty list.
- Labels {3,12,3,15,7} (12 and 15 >= NUM_CLASS).
  -> invalid labels ignored; out_label=3.
- Assert clear during FETCH with a read pending, then run a fresh 5-result pass.
  -> stale mem_ready ignored; result depends only on the new pass. Async reset mid-COLLECT gives in_ready=1, out_valid=0, mem_valid=0 immediately.
